// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_pipe data memory.
package dmem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Widest data word the lane-merge helper handles.
  localparam int MAX_WIDTH = 1024;

  // Bounds on the read-pipeline depth.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  // Replace each byte of old_word with the matching byte of new_word where lane_en is set.
  function automatic logic [MAX_WIDTH-1:0] merge_lanes(
    input logic [MAX_WIDTH-1:0]   old_word,
    input logic [MAX_WIDTH-1:0]   new_word,
    input logic [MAX_WIDTH/8-1:0] lane_en
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_WIDTH/8; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_bram_core.sv
// WIDTH x ENTRY byte-lane RAM: one write port with per-lane enables and a
// registered read-first output, shaped so synthesis maps it onto block RAM.
module dmem_bram_core #(
  parameter int WIDTH = 32,
  parameter int ENTRY = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [WIDTH/8-1:0]       we,
  input  logic [$clog2(ENTRY)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  localparam int NB = WIDTH / 8;

  logic [NB-1:0][7:0] mem [ENTRY];

  // Per-lane write; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
    end
  end

  // Read-first output register; holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_pipe.sv
// Single-port data memory with a valid/ready core port, priority loader port,
// post-reset clear sequencer and a 1- or 2-cycle response pipeline.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ENTRY        = 256,
  parameter int RD_LAT       = 1,
  parameter int WRITE_FIRST  = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [$clog2(ENTRY)-1:0] REQ_ADDR,
  input  logic [WIDTH/8-1:0]       REQ_WE,
  input  logic [WIDTH-1:0]         REQ_WDATA,
  output logic                     RSP_VALID,
  output logic [WIDTH-1:0]         RSP_DATA,
  input  logic                     LD_WE,
  input  logic [$clog2(ENTRY)-1:0] LD_ADDR,
  input  logic [WIDTH-1:0]         LD_DATA,
  output logic                     INIT_DONE
);

  localparam int AW = $clog2(ENTRY);
  localparam int NB = WIDTH / 8;

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("dmem_pipe: RD_LAT must be 1 or 2");
  end
  if ((WIDTH % 8) != 0 || WIDTH >= MAX_WIDTH) begin : g_bad_width
    $error("dmem_pipe: WIDTH must be a multiple of 8 below MAX_WIDTH");
  end
  if (ENTRY < 2 || (ENTRY & (ENTRY - 1)) != 0) begin : g_bad_entry
    $error("dmem_pipe: ENTRY must be a power of two");
  end

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_cnt;
  logic              clr_last;
  logic              accept;

  logic              mem_rd_en;
  logic [NB-1:0]     mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  rd_q;

  logic              v1;
  logic [WIDTH-1:0]  wd_q;
  logic [NB-1:0]     we_q;
  logic [WIDTH-1:0]  rsp_word;

  logic [MAX_WIDTH-1:0]   old_ext, new_ext, merged_ext;
  logic [MAX_WIDTH/8-1:0] en_ext;
  logic                   unused_merge_hi;

  assign clr_last = (clr_cnt == AW'(ENTRY - 1));
  assign accept   = REQ_VALID & REQ_READY;

  // State register; reset chooses whether the array is cleared first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave the clear once the last address has been written.
  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_last) state_d = S_RUN;
  end

  // Handshake, status and RAM port mux; loader beats the core, RST blocks everything.
  always_comb begin
    REQ_READY = 1'b0;
    INIT_DONE = 1'b0;
    mem_rd_en = 1'b0;
    mem_we    = '0;
    mem_addr  = REQ_ADDR;
    mem_wdata = REQ_WDATA;
    if (!RST) begin
      case (state_q)
        S_CLEAR: begin
          mem_we    = '1;
          mem_addr  = clr_cnt;
          mem_wdata = '0;
        end
        S_RUN: begin
          INIT_DONE = 1'b1;
          if (LD_WE) begin
            mem_we    = '1;
            mem_addr  = LD_ADDR;
            mem_wdata = LD_DATA;
          end else begin
            REQ_READY = 1'b1;
            if (REQ_VALID) begin
              mem_rd_en = 1'b1;
              mem_we    = REQ_WE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Clear address walker; wraps back to 0 as the clear completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_cnt <= '0;
    end else if (state_q == S_CLEAR) begin
      clr_cnt <= clr_cnt + AW'(1);
    end
  end

  dmem_bram_core #(
    .WIDTH (WIDTH),
    .ENTRY (ENTRY)
  ) u_core (
    .clk   (CLK),
    .rst   (RST),
    .rd_en (mem_rd_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rd_q)
  );

  // First response stage: valid flag plus the write lanes needed to rebuild the new word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1   <= 1'b0;
      wd_q <= '0;
      we_q <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        wd_q <= REQ_WDATA;
        we_q <= REQ_WE;
      end
    end
  end

  // The RAM returns the old word; overlay the written lanes for write-first responses.
  always_comb begin
    old_ext              = '0;
    old_ext[WIDTH-1:0]   = rd_q;
    new_ext              = '0;
    new_ext[WIDTH-1:0]   = wd_q;
    en_ext               = '0;
    en_ext[NB-1:0]       = we_q;
    merged_ext           = merge_lanes(old_ext, new_ext, en_ext);
  end

  assign unused_merge_hi = ^merged_ext[MAX_WIDTH-1:WIDTH];
  assign rsp_word        = (WRITE_FIRST != 0) ? merged_ext[WIDTH-1:0] : rd_q;

  if (RD_LAT == 2) begin : g_lat2
    logic             v2;
    logic [WIDTH-1:0] d2;

    // Extra output register stage.
    always_ff @(posedge CLK) begin
      if (RST) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= rsp_word;
      end
    end

    assign RSP_VALID = v2;
    assign RSP_DATA  = d2;
  end else begin : g_lat1
    assign RSP_VALID = v1;
    assign RSP_DATA  = rsp_word;
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: instance a (RD_LAT=1, read-old, clearing) and
// instance b (RD_LAT=2, write-first, no clear), both ENTRY=16, WIDTH=32.
module tb_dmem_pipe;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          a_rst, a_req_valid, a_req_ready, a_rsp_valid, a_ld_we, a_init_done;
  logic [AW-1:0] a_req_addr, a_ld_addr;
  logic [NB-1:0] a_req_we;
  logic [W-1:0]  a_req_wdata, a_rsp_data, a_ld_data;

  logic          b_rst, b_req_valid, b_req_ready, b_rsp_valid, b_ld_we, b_init_done;
  logic [AW-1:0] b_req_addr, b_ld_addr;
  logic [NB-1:0] b_req_we;
  logic [W-1:0]  b_req_wdata, b_rsp_data, b_ld_data;

  logic [W-1:0] lat_vals [4] = '{32'h0A0B0C0D, 32'h11111111, 32'h2222FFFF, 32'h80000001};

  dmem_pipe #(.WIDTH(W), .ENTRY(N), .RD_LAT(1), .WRITE_FIRST(0), .CLEAR_ON_RST(1)) u_a (
    .CLK(clk), .RST(a_rst), .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready),
    .REQ_ADDR(a_req_addr), .REQ_WE(a_req_we), .REQ_WDATA(a_req_wdata),
    .RSP_VALID(a_rsp_valid), .RSP_DATA(a_rsp_data), .LD_WE(a_ld_we),
    .LD_ADDR(a_ld_addr), .LD_DATA(a_ld_data), .INIT_DONE(a_init_done)
  );

  dmem_pipe #(.WIDTH(W), .ENTRY(N), .RD_LAT(2), .WRITE_FIRST(1), .CLEAR_ON_RST(0)) u_b (
    .CLK(clk), .RST(b_rst), .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready),
    .REQ_ADDR(b_req_addr), .REQ_WE(b_req_we), .REQ_WDATA(b_req_wdata),
    .RSP_VALID(b_rsp_valid), .RSP_DATA(b_rsp_data), .LD_WE(b_ld_we),
    .LD_ADDR(b_ld_addr), .LD_DATA(b_ld_data), .INIT_DONE(b_init_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic v, input logic [AW-1:0] ad, input logic [NB-1:0] we, input logic [W-1:0] wd);
    a_req_valid = v; a_req_addr = ad; a_req_we = we; a_req_wdata = wd;
  endtask

  task automatic b_set(input logic v, input logic [AW-1:0] ad, input logic [NB-1:0] we, input logic [W-1:0] wd);
    b_req_valid = v; b_req_addr = ad; b_req_we = we; b_req_wdata = wd;
  endtask

  task automatic test_reset;
    int n;
    a_rst = 1'b1; b_rst = 1'b1;
    a_set(1'b0, '0, '0, '0); b_set(1'b0, '0, '0, '0);
    a_ld_we = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    b_ld_we = 1'b0; b_ld_addr = '0; b_ld_data = '0;
    tick; tick;
    total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%b exp=0", a_req_ready); end
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_a_rsp_valid got=%b exp=0", a_rsp_valid); end
    total++; if (a_rsp_data !== 32'h0) begin bad++; $display("FAIL rst_a_rsp_data got=%h exp=0", a_rsp_data); end
    total++; if (a_init_done !== 1'b0) begin bad++; $display("FAIL rst_a_init got=%b exp=0", a_init_done); end
    total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready got=%b exp=0", b_req_ready); end
    total++; if (b_init_done !== 1'b0) begin bad++; $display("FAIL rst_b_init got=%b exp=0", b_init_done); end
    total++; if (b_rsp_data !== 32'h0) begin bad++; $display("FAIL rst_b_rsp_data got=%h exp=0", b_rsp_data); end
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    total++; if (b_init_done !== 1'b1) begin bad++; $display("FAIL noclr_b_init got=%b exp=1", b_init_done); end
    total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL noclr_b_ready got=%b exp=1", b_req_ready); end
    total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL clr_a_ready got=%b exp=0", a_req_ready); end
    n = 0;
    while (!a_init_done && n < 100) begin tick; n++; end
    total++; if (n !== 16) begin bad++; $display("FAIL clr_duration got=%0d exp=16", n); end
  endtask

  task automatic test_clear;
    int n;
    int seen;
    a_ld_we = 1'b1; a_ld_addr = 4'd5; a_ld_data = 32'hDEADBEEF;
    tick;
    a_ld_we = 1'b0;
    a_set(1'b1, 4'd5, 4'h0, '0);
    tick;
    a_set(1'b0, '0, '0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL prefill_read got=%b/%h exp=1/deadbeef", a_rsp_valid, a_rsp_data); end
    a_rst = 1'b1;
    tick;
    a_rst = 1'b0;
    n = 0; seen = 0;
    while (!a_init_done && n < 100) begin tick; n++; if (a_rsp_valid) seen++; end
    total++; if (n !== 16) begin bad++; $display("FAIL clear_duration got=%0d exp=16", n); end
    total++; if (seen !== 0) begin bad++; $display("FAIL clear_no_rsp got=%0d exp=0", seen); end
    a_set(1'b1, 4'd5, 4'h0, '0);
    tick;
    a_set(1'b0, '0, '0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0) begin bad++; $display("FAIL clear_read5 got=%b/%h exp=1/00000000", a_rsp_valid, a_rsp_data); end
  endtask

  task automatic test_byte_lanes;
    a_set(1'b1, 4'd3, 4'hF, 32'h11223344);
    tick;
    a_set(1'b1, 4'd3, 4'h2, 32'hAABBCCDD);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0) begin bad++; $display("FAIL lane_wr1_old got=%b/%h exp=1/00000000", a_rsp_valid, a_rsp_data); end
    tick;
    a_set(1'b1, 4'd3, 4'h0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h11223344) begin bad++; $display("FAIL lane_wr2_old got=%b/%h exp=1/11223344", a_rsp_valid, a_rsp_data); end
    tick;
    a_set(1'b0, '0, '0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h1122CC44) begin bad++; $display("FAIL lane_read got=%b/%h exp=1/1122cc44", a_rsp_valid, a_rsp_data); end
    tick;
    total++; if (a_rsp_valid !== 1'b0 || a_rsp_data !== 32'h1122CC44) begin bad++; $display("FAIL rsp_hold got=%b/%h exp=0/1122cc44", a_rsp_valid, a_rsp_data); end
  endtask

  task automatic test_back_to_back;
    a_set(1'b1, 4'd4, 4'hF, 32'h5A5AA5A5);
    tick;
    a_set(1'b1, 4'd4, 4'h0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0) begin bad++; $display("FAIL b2b_wr got=%b/%h exp=1/00000000", a_rsp_valid, a_rsp_data); end
    tick;
    a_set(1'b0, '0, '0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h5A5AA5A5) begin bad++; $display("FAIL b2b_rd got=%b/%h exp=1/5a5aa5a5", a_rsp_valid, a_rsp_data); end
    tick;
  endtask

  task automatic test_write_mode;
    a_set(1'b1, 4'd7, 4'h1, 32'h00000055);
    tick;
    a_set(1'b0, '0, '0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0) begin bad++; $display("FAIL wmode_old got=%b/%h exp=1/00000000", a_rsp_valid, a_rsp_data); end
    b_ld_we = 1'b1; b_ld_addr = 4'd7; b_ld_data = 32'h0;
    tick;
    b_ld_we = 1'b0;
    b_set(1'b1, 4'd7, 4'h1, 32'h00000055);
    tick;
    b_set(1'b1, 4'd7, 4'h4, 32'hAABBCCDD);
    total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL wmode_b_early got=%b exp=0", b_rsp_valid); end
    tick;
    b_set(1'b0, '0, '0, '0);
    total++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h00000055) begin bad++; $display("FAIL wmode_new got=%b/%h exp=1/00000055", b_rsp_valid, b_rsp_data); end
    tick;
    total++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h00BB0055) begin bad++; $display("FAIL wmode_merge got=%b/%h exp=1/00bb0055", b_rsp_valid, b_rsp_data); end
    tick;
  endtask

  task automatic test_loader_priority;
    a_set(1'b1, 4'd2, 4'h0, '0);
    a_ld_we = 1'b1; a_ld_addr = 4'd2; a_ld_data = 32'h12345678;
    #1;
    total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL ld_stall_ready got=%b exp=0", a_req_ready); end
    tick;
    a_ld_we = 1'b0;
    #1;
    total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL ld_after_ready got=%b exp=1", a_req_ready); end
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL ld_no_rsp got=%b exp=0", a_rsp_valid); end
    tick;
    a_set(1'b0, '0, '0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h12345678) begin bad++; $display("FAIL ld_read got=%b/%h exp=1/12345678", a_rsp_valid, a_rsp_data); end
    tick;
  endtask

  task automatic test_latency;
    for (int i = 0; i < 4; i++) begin
      b_ld_we = 1'b1; b_ld_addr = AW'(i); b_ld_data = lat_vals[i];
      tick;
    end
    b_ld_we = 1'b0;
    tick; tick;
    for (int i = 0; i < 7; i++) begin
      b_set(i < 4, AW'(i), 4'h0, '0);
      #1;
      if (i < 4) begin
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL lat_ready[%0d] got=%b exp=1", i, b_req_ready); end
      end
      total++; if (b_rsp_valid !== ((i >= 2) && (i <= 5))) begin bad++; $display("FAIL lat_valid[%0d] got=%b exp=%b", i, b_rsp_valid, (i >= 2) && (i <= 5)); end
      if (i >= 2 && i <= 5) begin
        total++; if (b_rsp_data !== lat_vals[i-2]) begin bad++; $display("FAIL lat_data[%0d] got=%h exp=%h", i, b_rsp_data, lat_vals[i-2]); end
      end
      tick;
    end
    b_set(1'b0, '0, '0, '0);
  endtask

  task automatic test_reset_flush;
    b_set(1'b1, 4'd0, 4'h0, '0);
    tick;
    b_set(1'b0, '0, '0, '0);
    b_rst = 1'b1;
    tick;
    total++; if (b_rsp_valid !== 1'b0 || b_rsp_data !== 32'h0) begin bad++; $display("FAIL flush_b got=%b/%h exp=0/00000000", b_rsp_valid, b_rsp_data); end
    b_rst = 1'b0;
    tick;
    total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_b_after got=%b exp=0", b_rsp_valid); end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    int seen;
    a_rst = 1'b1;
    tick;
    a_rst = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    a_set(1'b1, 4'd3, 4'h0, '0);
    #1;
    total++; if (a_req_ready !== 1'b0 || a_init_done !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b/%b exp=0/0", a_req_ready, a_init_done); end
    a_rst = 1'b1;
    tick;
    a_rst = 1'b0;
    n = 0; seen = 0;
    while (!a_init_done && n < 100) begin tick; n++; if (a_rsp_valid) seen++; end
    a_set(1'b0, '0, '0, '0);
    total++; if (n !== 16) begin bad++; $display("FAIL midclr_duration got=%0d exp=16", n); end
    total++; if (seen !== 0) begin bad++; $display("FAIL midclr_no_rsp got=%0d exp=0", seen); end
    a_set(1'b1, 4'd3, 4'h0, '0);
    tick;
    a_set(1'b0, '0, '0, '0);
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0) begin bad++; $display("FAIL midclr_read3 got=%b/%h exp=1/00000000", a_rsp_valid, a_rsp_data); end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_byte_lanes;
    test_back_to_back;
    test_write_mode;
    test_loader_priority;
    test_latency;
    test_reset_flush;
    test_reset_mid_clear;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
